// File: rtl/imem_program_writer_pkg.sv
// Shared RV32I encoding constants, descriptor classes, error codes and the
// writer FSM state encoding used by the instruction memory programmer.
package riscv_pkg;

  // Major opcodes of the supported RV32I subset
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Descriptor class codes carried on desc_class
  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_RTYPE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_ITYPE  = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_LUI    = 3'd6,
    CLS_RSVD   = 3'd7
  } desc_class_e;

  // Sticky session error reported on err_code
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_OVERFLOW = 2'b10
  } err_code_e;

  // Writer session FSM
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  // True when imm is representable as a signed value of 'bits' bits, i.e.
  // everything from bit bits-1 upward is a copy of the sign.
  function automatic logic immFits(input logic [31:0] imm, input int unsigned bits);
    logic signed [31:0] shifted;
    shifted = $signed(imm) >>> (bits - 1);
    return (shifted == '0) || (shifted == '1);
  endfunction

  // The ALU funct3 values this core's decode path implements
  function automatic logic aluFunct3Ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/imem_program_writer_if.sv
// Descriptor stream plus instruction memory write port of the programmer.
// The host side drives descriptors (master); the writer consumes them and
// drives the memory write port (slave).
interface imem_program_writer_if #(
  parameter int IMEM_DEPTH = 64
) ();

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  logic              desc_valid;
  logic              desc_ready;
  logic [2:0]        desc_class;
  logic [4:0]        desc_rd;
  logic [4:0]        desc_rs1;
  logic [4:0]        desc_rs2;
  logic [2:0]        desc_funct3;
  logic              desc_funct7b5;
  logic [31:0]       desc_imm;
  logic              desc_last;

  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output desc_valid, desc_class, desc_rd, desc_rs1, desc_rs2,
           desc_funct3, desc_funct7b5, desc_imm, desc_last,
    input  desc_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  desc_valid, desc_class, desc_rd, desc_rs1, desc_rs2,
           desc_funct3, desc_funct7b5, desc_imm, desc_last,
    output desc_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_program_writer_encoder.sv
// Combinational translation of one field-level descriptor into an RV32I
// instruction word, flagging descriptors the core could not execute.
module rv_instr_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  class_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  desc_class_e cls;

  assign cls = desc_class_e'(class_i);

  // Field packing per instruction format and legality of the requested encoding
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (cls)
      CLS_LOAD: begin
        word_o    = {imm_i[11:0], rs1_i, 3'b010, rd_i, OP_LOAD};
        illegal_o = !immFits(imm_i, 12);
      end
      CLS_STORE: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OP_STORE};
        illegal_o = !immFits(imm_i, 12);
      end
      CLS_RTYPE: begin
        word_o    = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
        illegal_o = !aluFunct3Ok(funct3_i) || (funct7b5_i && (funct3_i != 3'b000));
      end
      CLS_BRANCH: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                     imm_i[4:1], imm_i[11], OP_BRANCH};
        illegal_o = !immFits(imm_i, 13) || imm_i[0];
      end
      CLS_ITYPE: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ITYPE};
        illegal_o = !aluFunct3Ok(funct3_i) || funct7b5_i || !immFits(imm_i, 12);
      end
      CLS_JAL: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        illegal_o = !immFits(imm_i, 21) || imm_i[0];
      end
      CLS_LUI: begin
        word_o    = {imm_i[31:12], rd_i, OP_LUI};
        illegal_o = (imm_i[11:0] != 12'd0);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_writer.sv
// Boot-time instruction memory programmer: accepts descriptors one per
// cycle, encodes them and writes the words to consecutive addresses from 0.
module imem_program_writer
  import riscv_pkg::*;
#(
  parameter  int IMEM_DEPTH = 64,
  localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  imem_program_writer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err_code,
  output logic [ADDR_W:0]      word_count
);

  localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] LAST_SLOT_W = (ADDR_W + 1)'(IMEM_DEPTH - 1);

  state_e            state_q, state_d;
  err_code_e         err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;

  logic              descReady;
  logic              accept;
  logic              writeAccept;
  logic              clearSession;
  logic [ADDR_W:0]   slotIdx;
  logic              lastSlot;
  logic [31:0]       encWord;
  logic              encIllegal;

  rv_instr_encoder u_encoder (
    .class_i    (bus.desc_class),
    .rd_i       (bus.desc_rd),
    .rs1_i      (bus.desc_rs1),
    .rs2_i      (bus.desc_rs2),
    .funct3_i   (bus.desc_funct3),
    .funct7b5_i (bus.desc_funct7b5),
    .imm_i      (bus.desc_imm),
    .word_o     (encWord),
    .illegal_o  (encIllegal)
  );

  // A write may still be pending from the previous handshake, so the slot a
  // new descriptor lands in is the committed count plus that pending word.
  assign descReady   = (state_q == S_LOAD) && (count_q < DEPTH_W);
  assign accept      = bus.desc_valid && descReady;
  assign writeAccept = accept && !encIllegal;
  assign slotIdx     = count_q + {{ADDR_W{1'b0}}, we_q};
  assign lastSlot    = (slotIdx == LAST_SLOT_W);

  // Next-state logic: session start, descriptor outcomes and write draining
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    clearSession = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_LOAD;
          err_d        = ERR_NONE;
          ovf_d        = 1'b0;
          clearSession = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (encIllegal) begin
            state_d = S_ERROR;
            err_d   = ERR_ILLEGAL;
          end else if (bus.desc_last) begin
            state_d = S_FLUSH;
          end else if (lastSlot) begin
            state_d = S_FLUSH;
            ovf_d   = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (ovf_q) begin
          state_d = S_ERROR;
          err_d   = ERR_OVERFLOW;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Registered write port; address and count advance as each write retires
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      we_q <= writeAccept;
      if (writeAccept) begin
        wdata_q <= encWord;
      end
      if (clearSession) begin
        addr_q  <= '0;
        count_q <= '0;
      end else if (we_q) begin
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W + 1)'(1);
      end
    end
  end

  assign bus.desc_ready = descReady;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done           = (state_q == S_DONE);
  assign err_code       = err_q;
  assign word_count     = count_q;

endmodule

// File: tb/tb_imem_program_writer.sv
// Self-checking bench for imem_program_writer: table-driven descriptor
// sessions with a write scoreboard, plus error, reset and overflow sequences.
module tb_imem_program_writer;
  import riscv_pkg::*;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        last;
    logic [31:0] expWord;
    logic        expLegal;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  logic       busy, done, busy4, done4;
  logic [1:0] errCode, errCode4;
  logic [6:0] wordCount;
  logic [2:0] wordCount4;

  int   compared = 0;
  int   mismatched = 0;
  int   expAddr = 0;
  sb_t  expQ[$];
  sb_t  expQ4[$];
  sb_t  mon, mon4;
  vec_t goodVec[12];
  vec_t badVec[11];
  bit   got4;

  always #5 clk = ~clk;

  imem_program_writer_if #(.IMEM_DEPTH(64)) bus ();
  imem_program_writer_if #(.IMEM_DEPTH(4))  bus4 ();

  imem_program_writer #(.IMEM_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .err_code(errCode), .word_count(wordCount)
  );

  imem_program_writer #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bus(bus4),
    .busy(busy4), .done(done4), .err_code(errCode4), .word_count(wordCount4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                              input logic [31:0] imm, input logic last,
                              input logic [31:0] word, input logic legal);
    vec_t v;
    v.cls = cls; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.last = last; v.expWord = word; v.expLegal = legal;
    return v;
  endfunction

  // Scoreboard for the 64-deep writer: every write must match the oldest expectation
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: addr %0d data 0x%08h, no write expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon = expQ.pop_front();
        checkOutput("wr_addr", 32'(bus.imem_addr), mon.addr);
        checkOutput("wr_data", bus.imem_wdata, mon.data);
      end
    end
  end

  // Scoreboard for the 4-deep writer used by the overflow sequence
  always @(negedge clk) begin
    if (bus4.imem_we === 1'b1) begin
      if (expQ4.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write4: addr %0d data 0x%08h, no write expected",
                 bus4.imem_addr, bus4.imem_wdata);
      end else begin
        mon4 = expQ4.pop_front();
        checkOutput("wr4_addr", 32'(bus4.imem_addr), mon4.addr);
        checkOutput("wr4_data", bus4.imem_wdata, mon4.data);
      end
    end
  end

  task automatic driveDesc(input vec_t v);
    bus.desc_class    = v.cls;
    bus.desc_rd       = v.rd;
    bus.desc_rs1      = v.rs1;
    bus.desc_rs2      = v.rs2;
    bus.desc_funct3   = v.f3;
    bus.desc_funct7b5 = v.f7;
    bus.desc_imm      = v.imm;
    bus.desc_last     = v.last;
  endtask

  // Present one descriptor with valid held; it must be taken without stalling
  task automatic applyStimulus(input vec_t v, input string tag);
    int waits = 0;
    bit got = 1'b0;
    driveDesc(v);
    bus.desc_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.desc_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    checkOutput({tag, "_accepted"}, 32'(got), 32'd1);
    checkOutput({tag, "_stall"}, waits, 32'd0);
    if (got) begin
      if (v.expLegal) begin
        expQ.push_back('{addr: expAddr, data: v.expWord});
        expAddr++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    expAddr = 0;
  endtask

  task automatic waitDone(input int expCount, input string tag);
    bit seen = 1'b0;
    bus.desc_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_count"}, 32'(wordCount), expCount);
    checkOutput({tag, "_err"}, 32'(errCode), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_drained"}, expQ.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sessCount;
    // Legal sessions: each ends with a last descriptor
    goodVec[0]  = mk(CLS_ITYPE,  5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5,          1'b1, 32'h00500093, 1'b1);
    goodVec[1]  = mk(CLS_LOAD,   5'd2, 5'd1, 5'd0, 3'b111, 1'b0, 32'd8,          1'b0, 32'h0080A103, 1'b1);
    goodVec[2]  = mk(CLS_STORE,  5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd12,         1'b0, 32'h0020A623, 1'b1);
    goodVec[3]  = mk(CLS_RTYPE,  5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0,          1'b0, 32'h002081B3, 1'b1);
    goodVec[4]  = mk(CLS_RTYPE,  5'd4, 5'd3, 5'd1, 3'b000, 1'b1, 32'd0,          1'b1, 32'h40118233, 1'b1);
    goodVec[5]  = mk(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFFFFF8,   1'b0, 32'hFE208CE3, 1'b1);
    goodVec[6]  = mk(CLS_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd16,         1'b0, 32'h010000EF, 1'b1);
    goodVec[7]  = mk(CLS_LUI,    5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000,   1'b1, 32'h123452B7, 1'b1);
    goodVec[8]  = mk(CLS_ITYPE,  5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFF800,   1'b0, 32'h80000093, 1'b1);
    goodVec[9]  = mk(CLS_ITYPE,  5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2047,       1'b0, 32'h7FF00093, 1'b1);
    goodVec[10] = mk(CLS_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4094,       1'b0, 32'h7E000FE3, 1'b1);
    goodVec[11] = mk(CLS_JAL,    5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFF00000,   1'b1, 32'h8000006F, 1'b1);

    // Illegal descriptors, each in a session of its own
    badVec[0]  = mk(3'd7,       5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0,        1'b0, 32'h0, 1'b0);
    badVec[1]  = mk(CLS_RTYPE,  5'd1, 5'd0, 5'd0, 3'b001, 1'b0, 32'd0,        1'b0, 32'h0, 1'b0);
    badVec[2]  = mk(CLS_RTYPE,  5'd1, 5'd0, 5'd0, 3'b010, 1'b1, 32'd0,        1'b0, 32'h0, 1'b0);
    badVec[3]  = mk(CLS_ITYPE,  5'd1, 5'd0, 5'd0, 3'b000, 1'b1, 32'd0,        1'b0, 32'h0, 1'b0);
    badVec[4]  = mk(CLS_LOAD,   5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048,     1'b0, 32'h0, 1'b0);
    badVec[5]  = mk(CLS_STORE,  5'd0, 5'd0, 5'd1, 3'b000, 1'b0, 32'hFFFFF7FF, 1'b0, 32'h0, 1'b0);
    badVec[6]  = mk(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd4096,     1'b0, 32'h0, 1'b0);
    badVec[7]  = mk(CLS_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd17,       1'b0, 32'h0, 1'b0);
    badVec[8]  = mk(CLS_LUI,    5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345001, 1'b0, 32'h0, 1'b0);
    badVec[9]  = mk(CLS_RTYPE,  5'd1, 5'd0, 5'd0, 3'b011, 1'b0, 32'd0,        1'b1, 32'h0, 1'b0);
    badVec[10] = mk(CLS_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h00100000, 1'b0, 32'h0, 1'b0);

    bus.desc_valid = 1'b0;
    driveDesc(badVec[0]);
    bus4.desc_valid = 1'b0; bus4.desc_class = 3'd0; bus4.desc_rd = 5'd0; bus4.desc_rs1 = 5'd0;
    bus4.desc_rs2 = 5'd0; bus4.desc_funct3 = 3'd0; bus4.desc_funct7b5 = 1'b0;
    bus4.desc_imm = 32'd0; bus4.desc_last = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_ready", 32'(bus.desc_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(errCode), 32'd0);
    checkOutput("rst_count", 32'(wordCount), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Legal sessions from the table, valid held between descriptors
    sessCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || goodVec[i-1].last) begin
        pulseStart();
        sessCount = 0;
        checkOutput($sformatf("good%0d_busy_at_start", i), 32'(busy), 32'd1);
      end
      applyStimulus(goodVec[i], $sformatf("good%0d", i));
      sessCount++;
      if (goodVec[i].last) waitDone(sessCount, $sformatf("good%0d", i));
    end

    // Illegal descriptors: consumed, nothing written, sticky error
    for (int i = 0; i < 11; i++) begin
      pulseStart();
      applyStimulus(badVec[i], $sformatf("bad%0d", i));
      bus.desc_valid = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("bad%0d_err", i), 32'(errCode), 32'd1);
      checkOutput($sformatf("bad%0d_ready", i), 32'(bus.desc_ready), 32'd0);
      checkOutput($sformatf("bad%0d_count", i), 32'(wordCount), 32'd0);
      checkOutput($sformatf("bad%0d_done", i), 32'(done), 32'd0);
      checkOutput($sformatf("bad%0d_busy", i), 32'(busy), 32'd0);
    end

    // One legal word followed by a misaligned branch, then restart
    pulseStart();
    applyStimulus(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0, 32'h00500093, 1'b1), "mix_ok");
    applyStimulus(badVec[0].cls == 3'd7 ?
                  mk(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3, 1'b0, 32'h0, 1'b0) : badVec[0],
                  "mix_bad");
    bus.desc_valid = 1'b0;
    @(negedge clk);
    checkOutput("mix_err", 32'(errCode), 32'd1);
    checkOutput("mix_ready", 32'(bus.desc_ready), 32'd0);
    checkOutput("mix_count", 32'(wordCount), 32'd1);
    checkOutput("mix_drained", expQ.size(), 32'd0);
    pulseStart();
    @(negedge clk);
    checkOutput("restart_err", 32'(errCode), 32'd0);
    checkOutput("restart_count", 32'(wordCount), 32'd0);
    checkOutput("restart_ready", 32'(bus.desc_ready), 32'd1);

    // Reset asserted on the edge of the second handshake drops that word
    pulseStart();
    applyStimulus(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0, 32'h00500093, 1'b1), "rs_first");
    driveDesc(mk(CLS_ITYPE, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7, 1'b0, 32'h00700113, 1'b1));
    @(negedge clk);
    checkOutput("rs_ready2", 32'(bus.desc_ready), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 bus.desc_valid = 1'b0;
    @(negedge clk);
    checkOutput("rs_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rs_count", 32'(wordCount), 32'd0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_ready", 32'(bus.desc_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulseStart();
    applyStimulus(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b1, 32'h00500093, 1'b1), "rs_after");
    waitDone(1, "rs_after");

    // Overflow on a 4-word memory: four writes, fifth descriptor refused
    @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus4.desc_class = CLS_ITYPE;
      bus4.desc_rd    = 5'(i + 1);
      bus4.desc_imm   = 32'(i);
      bus4.desc_valid = 1'b1;
      got4 = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus4.desc_ready === 1'b1) begin
          got4 = 1'b1;
          break;
        end
      end
      checkOutput($sformatf("ovf_accept%0d", i), 32'(got4), (i < 4) ? 32'd1 : 32'd0);
      if (got4) begin
        expQ4.push_back('{addr: 32'(i), data: (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13});
        @(posedge clk);
        #1;
      end
    end
    bus4.desc_valid = 1'b0;
    @(negedge clk);
    checkOutput("ovf_err", 32'(errCode4), 32'd2);
    checkOutput("ovf_ready", 32'(bus4.desc_ready), 32'd0);
    checkOutput("ovf_count", 32'(wordCount4), 32'd4);
    checkOutput("ovf_done", 32'(done4), 32'd0);
    checkOutput("ovf_busy", 32'(busy4), 32'd0);
    checkOutput("ovf_drained", expQ4.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
